// File: rtl/alu_pkg.sv
// Opcodes, sequencer state encoding and opcode classification shared by the
// control unit, the ALU op sequencer and the ALU bench.
package alu_pkg;

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } seqState_t;

  function automatic logic is_legal_op(input logic [4:0] op);
    return ((op >= OP_ADD) && (op <= OP_ROL)) || ((op >= OP_MUL) && (op <= OP_NOT));
  endfunction

  function automatic logic is_long_op(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; the pointer is owned and advanced by the caller.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       en,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    if (en) begin
      if (req == 2'b11) grant = ptr ? 2'b10 : 2'b01;
      else              grant = req;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Shares one combinational ALU between two requesters: arbitrate, hold the
// operands for a per-op settle time, capture Z and hand it back via valid/ready.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int OP_W        = 5,
  parameter int MULDIV_WAIT = 4,
  parameter int SHORT_WAIT  = 1
) (
  input  logic                clock,
  input  logic                clear,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*OP_W-1:0]   req_op,
  input  logic [2*DATA_W-1:0] req_a,
  input  logic [2*DATA_W-1:0] req_b,
  output logic [1:0]          rsp_valid,
  input  logic [1:0]          rsp_ready,
  output logic [DATA_W-1:0]   rsp_hi,
  output logic [DATA_W-1:0]   rsp_lo,
  output logic                rsp_err,
  output logic [DATA_W-1:0]   alu_y,
  output logic [DATA_W-1:0]   alu_bus,
  output logic [OP_W-1:0]     alu_ctrl,
  input  logic [2*DATA_W-1:0] alu_z,
  output logic                busy
);

  localparam int CNT_W = $clog2(MULDIV_WAIT + 1);

  logic [1:0][OP_W-1:0]   reqOp;
  logic [1:0][DATA_W-1:0] reqA, reqB;
  assign reqOp = req_op;
  assign reqA  = req_a;
  assign reqB  = req_b;

  seqState_t         state, nextState;
  logic              rrPtr, gid, errReg;
  logic [OP_W-1:0]   opReg;
  logic [DATA_W-1:0] aReg, bReg;
  logic [2*DATA_W-1:0] zReg;
  logic [CNT_W-1:0]  cnt;

  logic [1:0]        grant;
  logic              accept, selGid, selErr, rspFire, lastExec;
  logic [OP_W-1:0]   selOp;
  logic [DATA_W-1:0] selA, selB;

  rr_arbiter2 uArb (
    .req   (req_valid),
    .ptr   (rrPtr),
    .en    (state == ST_IDLE),
    .grant (grant)
  );

  assign accept   = |grant;
  assign selGid   = grant[1];
  assign selOp    = reqOp[selGid];
  assign selA     = reqA[selGid];
  assign selB     = reqB[selGid];
  // Errors skip EXEC entirely so the ALU never sees an illegal op or a /0.
  assign selErr   = !is_legal_op(5'(selOp)) || ((5'(selOp) == OP_DIV) && (selB == '0));
  assign lastExec = (state == ST_EXEC) && (cnt == CNT_W'(1));
  assign rspFire  = (state == ST_RESP) && rsp_ready[gid];

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= ST_IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    req_ready = '0;
    rsp_valid = '0;
    alu_y     = '0;
    alu_bus   = '0;
    alu_ctrl  = '0;
    busy      = 1'b1;
    unique case (state)
      ST_IDLE: begin
        busy      = 1'b0;
        req_ready = grant;
        if (accept) nextState = selErr ? ST_RESP : ST_EXEC;
      end
      ST_EXEC: begin
        alu_y    = aReg;
        alu_bus  = bReg;
        alu_ctrl = opReg;
        if (lastExec) nextState = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid[gid] = 1'b1;
        if (rsp_ready[gid]) nextState = ST_IDLE;
      end
      default: nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      rrPtr  <= 1'b0;
      gid    <= 1'b0;
      errReg <= 1'b0;
      opReg  <= '0;
      aReg   <= '0;
      bReg   <= '0;
      zReg   <= '0;
      cnt    <= '0;
    end else begin
      if (accept) begin
        opReg <= selOp;
        aReg  <= selA;
        bReg  <= selB;
        gid   <= selGid;
        if (selErr) begin
          zReg   <= '0;
          errReg <= 1'b1;
          cnt    <= '0;
        end else begin
          errReg <= 1'b0;
          cnt    <= is_long_op(5'(selOp)) ? CNT_W'(MULDIV_WAIT) : CNT_W'(SHORT_WAIT);
        end
      end
      if (state == ST_EXEC) cnt <= cnt - CNT_W'(1);
      if (lastExec) zReg <= alu_z;
      if (rspFire) rrPtr <= ~gid;
    end
  end

  assign rsp_hi  = zReg[2*DATA_W-1:DATA_W];
  assign rsp_lo  = zReg[DATA_W-1:0];
  assign rsp_err = errReg;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: a behavioural ALU drives alu_z, and a
// cycle-count model of the transaction rules is checked on every falling edge.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  logic        clock = 1'b0;
  logic        clear;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [9:0]  req_op;
  logic [63:0] req_a, req_b, alu_z;
  logic [31:0] rsp_hi, rsp_lo, alu_y, alu_bus;
  logic        rsp_err, busy;
  logic [4:0]  alu_ctrl;

  int nChecks = 0;
  int nFail   = 0;
  int cyc     = 0;
  int mulCycles = 0;
  int nzCycles  = 0;

  alu_op_sequencer dut (
    .clock(clock), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .rsp_err(rsp_err),
    .alu_y(alu_y), .alu_bus(alu_bus), .alu_ctrl(alu_ctrl),
    .alu_z(alu_z), .busy(busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) begin
    if (alu_ctrl == OP_MUL) mulCycles++;
    if (alu_ctrl != 5'd0)   nzCycles++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural ALU (32-bit ops zero-extended into Z)
  function automatic logic [63:0] aluFn(input logic [4:0] op, input logic [31:0] y, input logic [31:0] b);
    case (op)
      OP_ADD:  return {32'd0, y + b};
      OP_SUB:  return {32'd0, y - b};
      OP_AND:  return {32'd0, y & b};
      OP_OR:   return {32'd0, y | b};
      OP_SHR:  return {32'd0, y >> b[4:0]};
      OP_SHL:  return {32'd0, y << b[4:0]};
      OP_MUL:  return {32'd0, y} * {32'd0, b};
      OP_DIV:  return (b == 0) ? 64'd0 : {y % b, y / b};
      OP_NEG:  return {32'd0, -y};
      OP_NOT:  return {32'd0, ~y};
      default: return 64'd0;
    endcase
  endfunction

  always_comb alu_z = aluFn(alu_ctrl, alu_y, alu_bus);

  // Expected response {err, hi, lo} for a request
  function automatic logic [64:0] specRsp(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!(op inside {[5'h03:5'h0B], [5'h0F:5'h12]}) || (op == OP_DIV && b == 0)) return {1'b1, 64'd0};
    return {1'b0, aluFn(op, a, b)};
  endfunction

  // Transaction-level model: one op in flight, timed from its accept cycle
  bit          mBusy, mPtr;
  int          mGid, mAcc, mWait;
  logic [4:0]  mOp;
  logic [31:0] mA, mB;
  logic [64:0] mExp;
  logic [1:0]  expG;

  always @(negedge clock) begin
    if (!clear) begin
      mBusy = 0; mPtr = 0;
      check("rst_busy", busy, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_alu_ctrl", alu_ctrl, 0);
      check("rst_rsp", {rsp_err, rsp_hi, rsp_lo}, 0);
    end else if (!mBusy) begin
      expG = (req_valid == 2'b11) ? (mPtr ? 2'b10 : 2'b01) : req_valid;
      check("m_req_ready", req_ready, expG);
      check("m_idle_busy", busy, 0);
      check("m_idle_rsp_valid", rsp_valid, 0);
      check("m_idle_alu", {alu_ctrl, alu_y, alu_bus}, 0);
      if (expG != 0) begin
        mBusy = 1;
        mGid  = expG[1] ? 1 : 0;
        mOp   = req_op[mGid*5 +: 5];
        mA    = req_a[mGid*32 +: 32];
        mB    = req_b[mGid*32 +: 32];
        mExp  = specRsp(mOp, mA, mB);
        mWait = mExp[64] ? 0 : ((mOp == OP_MUL || mOp == OP_DIV) ? 4 : 1);
        mAcc  = cyc;
      end
    end else begin
      check("m_busy_req_ready", req_ready, 0);
      check("m_busy", busy, 1);
      if (cyc > mAcc && cyc <= mAcc + mWait) begin
        check("m_alu_ctrl", alu_ctrl, mOp);
        check("m_alu_y", alu_y, mA);
        check("m_alu_bus", alu_bus, mB);
      end else begin
        check("m_alu_quiet", {alu_ctrl, alu_y, alu_bus}, 0);
      end
      if (cyc >= mAcc + mWait + 1) begin
        check("m_rsp_valid", rsp_valid, 2'b01 << mGid);
        check("m_rsp_hi", rsp_hi, mExp[63:32]);
        check("m_rsp_lo", rsp_lo, mExp[31:0]);
        check("m_rsp_err", rsp_err, mExp[64]);
        if (rsp_ready[mGid]) begin
          mBusy = 0;
          mPtr  = (mGid == 0);
        end
      end else begin
        check("m_rsp_early", rsp_valid, 0);
      end
    end
  end

  task automatic setReq(input int g, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[g*5 +: 5]  = op;
    req_a[g*32 +: 32] = a;
    req_b[g*32 +: 32] = b;
  endtask

  task automatic waitReady(input int g, output int t);
    bit got = 0;
    t = -1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clock);
      if (req_ready[g]) begin got = 1; t = cyc; end
    end
    if (!got) check("accept_timeout", 0, 1);
  endtask

  task automatic waitRsp(input int g, output int t);
    bit got = 0;
    t = -1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clock);
      if (rsp_valid[g]) begin got = 1; t = cyc; end
    end
    if (!got) check("rsp_timeout", 0, 1);
  endtask

  task automatic doOp(input int g, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      output logic [31:0] hi, output logic [31:0] lo, output logic err, output int lat);
    int tA, tR;
    @(posedge clock); #1;
    setReq(g, op, a, b);
    req_valid[g] = 1'b1;
    waitReady(g, tA);
    @(posedge clock); #1;
    req_valid[g] = 1'b0;
    waitRsp(g, tR);
    check("rsp_onehot", rsp_valid, 2'b01 << g);
    hi = rsp_hi; lo = rsp_lo; err = rsp_err;
    lat = tR - tA;
  endtask

  // Both requesters raise valid together; each drops its valid once accepted.
  task automatic contend(output int first, output logic [31:0] lo0, output logic [31:0] lo1);
    bit d0 = 0, d1 = 0;
    logic [1:0] rdy;
    first = -1; lo0 = '0; lo1 = '0;
    @(posedge clock); #1;
    setReq(0, OP_SUB, 32'd10, 32'd3);
    setReq(1, OP_AND, 32'hF0, 32'h3C);
    req_valid = 2'b11;
    for (int i = 0; i < 40 && !(d0 && d1); i++) begin
      @(negedge clock);
      rdy = req_ready;
      if (rsp_valid[0] && !d0) begin d0 = 1; lo0 = rsp_lo; if (first < 0) first = 0; end
      if (rsp_valid[1] && !d1) begin d1 = 1; lo1 = rsp_lo; if (first < 0) first = 1; end
      @(posedge clock); #1;
      req_valid = req_valid & ~rdy;
    end
    req_valid = 2'b00;
    if (!(d0 && d1)) check("contend_timeout", 0, 1);
  endtask

  logic [31:0] hi, lo, holdHi, holdLo;
  logic        err;
  int          lat, snap, first, tA, tR;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clear = 1'b0; req_valid = '0; rsp_ready = 2'b11;
    req_op = '0; req_a = '0; req_b = '0;
    repeat (3) @(posedge clock);
    #3 clear = 1'b1;

    // add on req0
    doOp(0, OP_ADD, 32'd5, 32'd7, hi, lo, err, lat);
    check("add_latency", lat, 2);
    check("add_lo", lo, 12);
    check("add_hi", hi, 0);
    check("add_err", err, 0);

    // mul on req1, operands held for the long settle time
    snap = mulCycles;
    doOp(1, OP_MUL, 32'h0001_0000, 32'h0001_0000, hi, lo, err, lat);
    check("mul_ctrl_cycles", mulCycles - snap, 4);
    check("mul_latency", lat, 5);
    check("mul_hi", hi, 1);
    check("mul_lo", lo, 0);

    // divide by zero and illegal opcode never reach the ALU
    snap = nzCycles;
    doOp(0, OP_DIV, 32'd9, 32'd0, hi, lo, err, lat);
    check("div0_latency", lat, 1);
    check("div0_err", err, 1);
    check("div0_z", {hi, lo}, 0);
    doOp(1, OP_NOP, 32'd9, 32'd4, hi, lo, err, lat);
    check("illegal_latency", lat, 1);
    check("illegal_err", err, 1);
    check("illegal_z", {hi, lo}, 0);
    check("err_alu_quiet", nzCycles - snap, 0);

    // contention: last served was req1, so req0 goes first
    contend(first, hi, lo);
    check("contendA_first", first, 0);
    check("contendA_sub", hi, 7);
    check("contendA_and", lo, 32'h30);
    doOp(0, OP_ADD, 32'd1, 32'd1, hi, lo, err, lat);
    contend(first, hi, lo);
    check("contendB_first", first, 1);
    check("contendB_sub", hi, 7);
    check("contendB_and", lo, 32'h30);

    // backpressure: req0 result held, req1 waits; rsp_ready[1] must be ignored
    @(posedge clock); #1;
    rsp_ready = 2'b10;
    setReq(0, OP_ADD, 32'd100, 32'd23);
    req_valid = 2'b01;
    waitReady(0, tA);
    @(posedge clock); #1;
    setReq(1, OP_OR, 32'd3, 32'd4);
    req_valid = 2'b10;
    waitRsp(0, tR);
    holdHi = rsp_hi; holdLo = rsp_lo;
    check("bp_lo", holdLo, 123);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("bp_valid", rsp_valid, 2'b01);
      check("bp_hold", {rsp_hi, rsp_lo}, {holdHi, holdLo});
      check("bp_req_ready", req_ready, 0);
    end
    @(posedge clock); #1;
    rsp_ready = 2'b11;
    @(negedge clock);
    @(negedge clock);
    check("bp_next_accept", req_ready, 2'b10);
    @(posedge clock); #1;
    req_valid = 2'b00;
    waitRsp(1, tR);
    check("bp_or_lo", rsp_lo, 7);

    // reset in the middle of a divide
    @(posedge clock); #1;
    setReq(1, OP_DIV, 32'd100, 32'd7);
    req_valid = 2'b10;
    waitReady(1, tA);
    @(posedge clock); #1;
    req_valid = 2'b00;
    @(negedge clock);
    check("div_exec_ctrl", alu_ctrl, OP_DIV);
    #2 clear = 1'b0;
    #1;
    check("rstmid_busy", busy, 0);
    check("rstmid_alu", {alu_ctrl, alu_y, alu_bus}, 0);
    check("rstmid_rsp_valid", rsp_valid, 0);
    @(posedge clock); #1;
    @(negedge clock); #2 clear = 1'b1;
    doOp(0, OP_ADD, 32'd20, 32'd22, hi, lo, err, lat);
    check("post_rst_latency", lat, 2);
    check("post_rst_lo", lo, 42);
    check("post_rst_err", err, 0);
    repeat (3) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
